pixel_brightness_adjust: RTL and testbench

Streaming per-pixel brightness adjuster, the parametrised successor to the fixed 8-bit RGB increase-only block. Takes packed multi-channel pixels over a valid/ready stream, adds a signed offset per frame (brighten or darken) with saturation to [0, 2^DATA_W-1], and emits them through a 2-stage pipeline with full backpressure. Tracks pixel position to mark end-of-frame and holds configuration stable for the whole frame. Sits between the image reader and the output writer.

---
 rtl/pixel_brightness_adjust.sv | 161 ++++++++++++++++
 tb/tb_pixel_brightness_adjust.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_brightness_adjust.sv
// pixel_brightness_adjust
//
// Streaming per-pixel brightness adjuster. Adds a signed per-frame offset to
// every channel of each pixel, saturating to [0, 2^DATA_W-1], through a
// two-stage valid/ready pipeline with full backpressure. Offset and bypass
// are sampled on the first pixel of each frame and held for the whole frame.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   cfg_offset  signed brightness offset (two's complement, DATA_W+1 bits)
//   cfg_bypass  1 = pass pixels unmodified
//   s_valid     input pixel valid
//   s_ready     block can accept an input pixel (combinational)
//   s_data      input pixel, channel 0 in the LSBs
//   m_valid     output pixel valid
//   m_ready     downstream accepts the output pixel
//   m_data      adjusted pixel
//   m_last      marks the last pixel of a frame (index WIDTH*HEIGHT-1)
//   frame_done  one-cycle pulse after the m_last pixel is accepted

module pixel_brightness_adjust #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 512,
    parameter int unsigned HEIGHT   = 768
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W:0]            cfg_offset,
    input  logic                       cfg_bypass,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CHANNELS*DATA_W-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CHANNELS*DATA_W-1:0] m_data,
    output logic                       m_last,
    output logic                       frame_done
);

    localparam int unsigned PIX_W = CHANNELS * DATA_W;
    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

    // Stage 1 (capture) state
    logic             v1_q, v1_d;
    logic [PIX_W-1:0] pix1_q;
    logic [DATA_W:0]  off1_q;
    logic             byp1_q;
    logic             last1_q;

    // Stage 2 (output) state
    logic             v2_q, v2_d;
    logic [PIX_W-1:0] m_data_q;
    logic             m_last_q;
    logic             done_q, done_d;

    // Frame bookkeeping
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W:0]  frame_off_q;
    logic             frame_byp_q;

    logic             in_xfer;
    logic             adv1;
    logic             first_pix;
    logic             cnt_at_last;
    logic [DATA_W:0]  cur_off;
    logic             cur_byp;
    logic [PIX_W-1:0] adj;

    assign s_ready     = !v1_q || !v2_q || m_ready;
    assign in_xfer     = s_valid && s_ready;
    // Stage 1 moves forward whenever stage 2 is empty or is being drained.
    assign adv1        = v1_q && (!v2_q || m_ready);
    assign first_pix   = (cnt_q == '0);
    assign cnt_at_last = (cnt_q == LAST_IDX);

    // Pixel 0 uses the live config; the rest of the frame uses the latched copy.
    assign cur_off = first_pix ? cfg_offset : frame_off_q;
    assign cur_byp = first_pix ? cfg_bypass : frame_byp_q;

    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer) begin
            cnt_d = cnt_at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        v1_d   = in_xfer || (v1_q && !adv1);
        v2_d   = adv1 || (v2_q && !m_ready);
        done_d = v2_q && m_ready && m_last_q;
    end

    // Per-channel saturating add. The sum is formed in DATA_W+2 bits so that the
    // top bit is the sign and the next bit flags overflow above full scale.
    always_comb begin : adjust
        logic [DATA_W-1:0] chan;
        logic [DATA_W+1:0] sum;
        adj  = '0;
        chan = '0;
        sum  = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            chan = pix1_q[c*DATA_W +: DATA_W];
            sum  = {2'b00, chan} + {off1_q[DATA_W], off1_q};
            if (byp1_q) begin
                adj[c*DATA_W +: DATA_W] = chan;
            end else if (sum[DATA_W+1]) begin
                adj[c*DATA_W +: DATA_W] = '0;
            end else if (sum[DATA_W]) begin
                adj[c*DATA_W +: DATA_W] = '1;
            end else begin
                adj[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            pix1_q      <= '0;
            off1_q      <= '0;
            byp1_q      <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            frame_off_q <= '0;
            frame_byp_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            if (in_xfer) begin
                pix1_q  <= s_data;
                off1_q  <= cur_off;
                byp1_q  <= cur_byp;
                last1_q <= cnt_at_last;
                if (first_pix) begin
                    frame_off_q <= cfg_offset;
                    frame_byp_q <= cfg_bypass;
                end
            end
            if (adv1) begin
                m_data_q <= adj;
                m_last_q <= last1_q;
            end
        end
    end

    assign m_valid    = v2_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_brightness_adjust.sv
// Directed testbench for pixel_brightness_adjust (WIDTH=4, HEIGHT=2 frames).
module tb_pixel_brightness_adjust;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int PW = DW * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW:0]   cfg_offset = '0;
    logic          cfg_bypass = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [PW-1:0] m_data;
    logic          m_last;
    logic          frame_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [PW-1:0] got_data[$];
    bit            got_last[$];
    int            got_cyc[$];
    int            done_cyc[$];

    pixel_brightness_adjust #(
        .DATA_W  (DW),
        .CHANNELS(CH),
        .WIDTH   (4),
        .HEIGHT  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_offset(cfg_offset),
        .cfg_bypass(cfg_bypass),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Output monitor: logs accepted pixels and frame_done pulses at the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            if (frame_done) done_cyc.push_back(cyc);
        end
    end

    function automatic logic [PW-1:0] px(input logic [7:0] c2, input logic [7:0] c1,
                                         input logic [7:0] c0);
        return {c2, c1, c0};
    endfunction

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
    endtask

    // Presents one pixel and returns 1 time unit after the edge that took it.
    task automatic send_pix(input logic [PW-1:0] d);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready got 0 required 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int guard = 0;
        while (got_data.size() < n && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL rst_m_valid_async: got %b required 0", m_valid);
        end
        do_reset();
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
        total++;
        if (m_data !== '0) begin bad++; $display("FAIL rst_m_data: got %h required 0", m_data); end
        total++;
        if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last: got %b required 0", m_last); end
        total++;
        if (frame_done !== 1'b0) begin
            bad++; $display("FAIL rst_frame_done: got %b required 0", frame_done);
        end
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_offset_pos();
        do_reset();
        cfg_offset = 9'd40;
        cfg_bypass = 1'b0;
        send_pix(px(8'd10, 8'd200, 8'd250));
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL pos_latency1: m_valid got %b required 0", m_valid); end
        @(posedge clk);
        #1;
        total++;
        if (m_valid !== 1'b1) begin bad++; $display("FAIL pos_latency2: m_valid got %b required 1", m_valid); end
        total++;
        if (m_data !== px(8'd50, 8'd240, 8'd255)) begin
            bad++; $display("FAIL pos_data: got %h required %h", m_data, px(8'd50, 8'd240, 8'd255));
        end
    endtask

    task automatic test_offset_neg_bypass();
        do_reset();
        cfg_offset = 9'h1E2;
        cfg_bypass = 1'b0;
        send_pix(px(8'd5, 8'd30, 8'd100));
        wait_out(1);
        total++;
        if (got_data.size() !== 1) begin
            bad++; $display("FAIL neg_count: got %0d required 1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== px(8'd0, 8'd0, 8'd70)) begin
                bad++; $display("FAIL neg_data: got %h required %h", got_data[0], px(8'd0, 8'd0, 8'd70));
            end
        end
        do_reset();
        cfg_bypass = 1'b1;
        send_pix(px(8'd5, 8'd30, 8'd100));
        cfg_bypass = 1'b0;
        wait_out(1);
        total++;
        if (got_data.size() !== 1) begin
            bad++; $display("FAIL byp_count: got %0d required 1", got_data.size());
        end else begin
            total++;
            if (got_data[0] !== px(8'd5, 8'd30, 8'd100)) begin
                bad++; $display("FAIL byp_data: got %h required %h", got_data[0], px(8'd5, 8'd30, 8'd100));
            end
        end
    endtask

    task automatic test_boundaries();
        logic [DW:0]   offs[3];
        logic [PW-1:0] exp_d[3];
        offs[0] = 9'd0;   exp_d[0] = px(8'd0, 8'd128, 8'd255);
        offs[1] = 9'h100; exp_d[1] = px(8'd0, 8'd0, 8'd0);
        offs[2] = 9'd255; exp_d[2] = px(8'd255, 8'd255, 8'd255);
        for (int k = 0; k < 3; k++) begin
            do_reset();
            cfg_offset = offs[k];
            send_pix(px(8'd0, 8'd128, 8'd255));
            wait_out(1);
            total++;
            if (got_data.size() !== 1) begin
                bad++; $display("FAIL bound%0d_count: got %0d required 1", k, got_data.size());
            end else begin
                total++;
                if (got_data[0] !== exp_d[k]) begin
                    bad++; $display("FAIL bound%0d_data: got %h required %h", k, got_data[0], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_frames();
        int n;
        logic [7:0] e;
        do_reset();
        cfg_offset = 9'd10;
        for (int i = 0; i < 16; i++) send_pix(px(8'(i), 8'(i), 8'(i)));
        wait_out(16);
        total++;
        if (got_data.size() !== 16) begin
            bad++; $display("FAIL frm_count: got %0d required 16", got_data.size());
        end
        n = (got_data.size() < 16) ? got_data.size() : 16;
        for (int i = 0; i < n; i++) begin
            e = 8'(i + 10);
            total++;
            if (got_data[i] !== px(e, e, e)) begin
                bad++; $display("FAIL frm_data%0d: got %h required %h", i, got_data[i], px(e, e, e));
            end
            total++;
            if (got_last[i] !== ((i == 7) || (i == 15))) begin
                bad++; $display("FAIL frm_last%0d: got %b required %b", i, got_last[i], (i == 7) || (i == 15));
            end
            if (i > 0) begin
                total++;
                if (got_cyc[i] !== got_cyc[i-1] + 1) begin
                    bad++; $display("FAIL frm_bubble%0d: got cycle %0d required %0d", i, got_cyc[i], got_cyc[i-1] + 1);
                end
            end
        end
        total++;
        if (done_cyc.size() !== 2) begin
            bad++; $display("FAIL frm_done_count: got %0d required 2", done_cyc.size());
        end else if (n == 16) begin
            total++;
            if (done_cyc[0] !== got_cyc[7] + 1) begin
                bad++; $display("FAIL frm_done0: got cycle %0d required %0d", done_cyc[0], got_cyc[7] + 1);
            end
            total++;
            if (done_cyc[1] !== got_cyc[15] + 1) begin
                bad++; $display("FAIL frm_done1: got cycle %0d required %0d", done_cyc[1], got_cyc[15] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] held;
        logic [PW-1:0] e;
        int n;
        do_reset();
        cfg_offset = 9'd0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_pix(px(8'(i * 3), 8'(i * 5), 8'(i * 7 + 1)));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    total++;
                    if (m_valid !== 1'b1) begin
                        bad++; $display("FAIL bp_valid%0d: got %b required 1", k, m_valid);
                    end
                    if (k == 0) held = m_data;
                    else begin
                        total++;
                        if (m_data !== held) begin
                            bad++; $display("FAIL bp_hold%0d: got %h required %h", k, m_data, held);
                        end
                    end
                    if (k == 4) begin
                        total++;
                        if (s_ready !== 1'b0) begin
                            bad++; $display("FAIL bp_s_ready: got %b required 0", s_ready);
                        end
                    end
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_out(8);
        total++;
        if (got_data.size() !== 8) begin
            bad++; $display("FAIL bp_count: got %0d required 8", got_data.size());
        end
        n = (got_data.size() < 8) ? got_data.size() : 8;
        for (int i = 0; i < n; i++) begin
            e = px(8'(i * 3), 8'(i * 5), 8'(i * 7 + 1));
            total++;
            if (got_data[i] !== e) begin
                bad++; $display("FAIL bp_order%0d: got %h required %h", i, got_data[i], e);
            end
        end
    endtask

    task automatic test_cfg_latch();
        logic [7:0] e;
        int n;
        do_reset();
        cfg_offset = 9'd10;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) cfg_offset = 9'd100;
            send_pix(px(8'(i * 16), 8'(i * 16), 8'(i * 16)));
        end
        send_pix(px(8'd50, 8'd50, 8'd50));
        wait_out(9);
        total++;
        if (got_data.size() !== 9) begin
            bad++; $display("FAIL cfg_count: got %0d required 9", got_data.size());
        end
        n = (got_data.size() < 8) ? got_data.size() : 8;
        for (int i = 0; i < n; i++) begin
            e = 8'(i * 16 + 10);
            total++;
            if (got_data[i] !== px(e, e, e)) begin
                bad++; $display("FAIL cfg_frame0_%0d: got %h required %h", i, got_data[i], px(e, e, e));
            end
        end
        if (got_data.size() >= 9) begin
            total++;
            if (got_data[8] !== px(8'd150, 8'd150, 8'd150)) begin
                bad++; $display("FAIL cfg_frame1_0: got %h required %h", got_data[8], px(8'd150, 8'd150, 8'd150));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        int n;
        do_reset();
        cfg_offset = 9'd5;
        m_ready = 1'b0;
        send_pix(px(8'd1, 8'd1, 8'd1));
        send_pix(px(8'd2, 8'd2, 8'd2));
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            bad++; $display("FAIL rm_full: got valid=%b ready=%b required valid=1 ready=0", m_valid, s_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b required 0", m_valid); end
        total++;
        if (m_data !== '0) begin bad++; $display("FAIL rm_data: got %h required 0", m_data); end
        total++;
        if (m_last !== 1'b0) begin bad++; $display("FAIL rm_last: got %b required 0", m_last); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        cfg_offset = 9'd20;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_pix(px(8'(i), 8'(i), 8'(i)));
        wait_out(8);
        total++;
        if (got_data.size() !== 8) begin
            bad++; $display("FAIL rm_count: got %0d required 8", got_data.size());
        end
        n = (got_data.size() < 8) ? got_data.size() : 8;
        for (int i = 0; i < n; i++) begin
            e = 8'(i + 20);
            total++;
            if (got_data[i] !== px(e, e, e)) begin
                bad++; $display("FAIL rm_data%0d: got %h required %h", i, got_data[i], px(e, e, e));
            end
            total++;
            if (got_last[i] !== (i == 7)) begin
                bad++; $display("FAIL rm_last%0d: got %b required %b", i, got_last[i], i == 7);
            end
        end
        total++;
        if (done_cyc.size() !== 1) begin
            bad++; $display("FAIL rm_done_count: got %0d required 1", done_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_offset_pos();
        test_offset_neg_bypass();
        test_boundaries();
        test_frames();
        test_backpressure();
        test_cfg_latch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
